// File: rtl/core_cmd_rsp_pkg.sv
// Shared constants and types for the core-side L3 command responder.
// Opcodes, bus widths and the one-hot FSM state set.
package core_cmd_rsp_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int SIZE_W = 16;

  localparam logic [7:0] OP_WR = 8'h01;
  localparam logic [7:0] OP_RD = 8'h02;

  localparam int I_IDLE    = 0;
  localparam int I_WRITE   = 1;
  localparam int I_RD_REQ  = 2;
  localparam int I_RD_WAIT = 3;
  localparam int I_RD_OUT  = 4;
  localparam int I_DONE    = 5;
  localparam int I_ERR     = 6;

  typedef enum logic [6:0] {
    IDLE    = 7'b0000001,
    WRITE   = 7'b0000010,
    RD_REQ  = 7'b0000100,
    RD_WAIT = 7'b0001000,
    RD_OUT  = 7'b0010000,
    DONE    = 7'b0100000,
    ERR     = 7'b1000000
  } state_t;

endpackage

// File: rtl/core_cmd_rsp_if.sv
// Command, byte-stream and memory-port bundle of core_cmd_rsp.
// master = issuer/memory side, slave = responder.
interface core_cmd_rsp_if;
  import core_cmd_rsp_pkg::*;

  logic              cmd_en;
  logic [7:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_extend;
  logic [SIZE_W-1:0] wr_size;
  logic              cmd_rdy;
  logic              wr_vld;
  logic [DATA_W-1:0] wr_data;
  logic              wr_rdy;
  logic              rd_vld;
  logic [DATA_W-1:0] rd_data;
  logic              rd_rdy;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              cmd_done;
  logic              cmd_err;

  modport master (
    output cmd_en, cmd_op, cmd_extend, wr_size,
    output wr_vld, wr_data, rd_rdy, mem_rdata,
    input  cmd_rdy, wr_rdy, rd_vld, rd_data,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  cmd_done, cmd_err
  );

  modport slave (
    input  cmd_en, cmd_op, cmd_extend, wr_size,
    input  wr_vld, wr_data, rd_rdy, mem_rdata,
    output cmd_rdy, wr_rdy, rd_vld, rd_data,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output cmd_done, cmd_err
  );

endinterface

// File: rtl/core_cmd_addr_cnt.sv
// Burst address incrementer (16-bit wrap) and remaining-byte counter.
// last flags the final byte of the burst.
module core_cmd_addr_cnt
  import core_cmd_rsp_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] addr_ld,
  input  logic [SIZE_W-1:0] cnt_ld,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [SIZE_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      addr <= '0;
      cnt  <= '0;
    end else if (load) begin
      addr <= addr_ld;
      cnt  <= cnt_ld;
    end else if (step) begin
      addr <= addr + ADDR_W'(1);
      cnt  <= cnt - SIZE_W'(1);
    end
  end

  assign last = (cnt == SIZE_W'(1));

endmodule

// File: rtl/core_cmd_rsp.sv
// Core-side L3 command responder: byte-wise write/read bursts
// against the core memory port, done/err reported as pulses.
module core_cmd_rsp
  import core_cmd_rsp_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_core,
  core_cmd_rsp_if.slave bus
);

  state_t            state;
  logic              cmd_rdy_q;
  logic [7:0]        op;
  logic [DATA_W-1:0] rd_data_q;
  logic [ADDR_W-1:0] addr;
  logic              last;
  logic              clr;
  logic              load;
  logic              wr_hs;
  logic              rd_hs;
  logic              wr_ok;
  logic              rd_ok;

  assign clr   = rst | clr_core;
  assign wr_ok = (bus.cmd_op == OP_WR) && (bus.wr_size != '0);
  assign rd_ok = (bus.cmd_op == OP_RD) && (bus.wr_size != '0);
  assign load  = state[I_IDLE] & bus.cmd_en;
  assign wr_hs = state[I_WRITE] & bus.wr_vld;
  assign rd_hs = state[I_RD_OUT] & bus.rd_rdy;

  core_cmd_addr_cnt u_addr_cnt (
    .clk     (clk),
    .clr     (clr),
    .load    (load),
    .step    (wr_hs | rd_hs),
    .addr_ld (bus.cmd_extend),
    .cnt_ld  (bus.wr_size),
    .addr    (addr),
    .last    (last)
  );

  // cmd_rdy is its own flop so it stays low through reset/clear
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      cmd_rdy_q <= 1'b0;
      op        <= '0;
      rd_data_q <= '0;
    end else begin
      cmd_rdy_q <= 1'b0;
      unique case (1'b1)
        state[I_IDLE]: begin
          cmd_rdy_q <= 1'b1;
          if (bus.cmd_en) begin
            op        <= bus.cmd_op;
            cmd_rdy_q <= 1'b0;
            if (wr_ok)      state <= WRITE;
            else if (rd_ok) state <= RD_REQ;
            else            state <= ERR;
          end
        end
        state[I_WRITE]:
          if (bus.wr_vld && last) state <= DONE;
        state[I_RD_REQ]:
          state <= RD_WAIT;
        state[I_RD_WAIT]: begin
          rd_data_q <= bus.mem_rdata;
          state     <= RD_OUT;
        end
        state[I_RD_OUT]:
          if (bus.rd_rdy) state <= last ? DONE : RD_REQ;
        state[I_DONE], state[I_ERR]: begin
          state     <= IDLE;
          cmd_rdy_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_rdy   = cmd_rdy_q;
  assign bus.wr_rdy    = state[I_WRITE];
  assign bus.rd_vld    = state[I_RD_OUT];
  assign bus.rd_data   = rd_data_q;
  assign bus.cmd_done  = state[I_DONE];
  assign bus.cmd_err   = state[I_ERR];
  assign bus.mem_en    = wr_hs | state[I_RD_REQ];
  assign bus.mem_we    = bus.mem_en & (op == OP_WR);
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = state[I_WRITE] ? bus.wr_data : '0;

endmodule

// File: tb/tb_core_cmd_rsp.sv
// Bench for core_cmd_rsp: table of commands, hand sequences and
// random bursts checked against a byte-level burst model.
module tb_core_cmd_rsp;
  import core_cmd_rsp_pkg::*;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] ext;
    logic [15:0] sz;
    int          pct;
    int          exp_end;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_core = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  logic [7:0] mem     [0:65535];
  bit         mem_vld [0:65535];
  logic [7:0] ref_mem [0:65535];
  vec_t       tbl     [14];

  core_cmd_rsp_if bus ();

  core_cmd_rsp dut (
    .clk      (clk),
    .rst      (rst),
    .clr_core (clr_core),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  // memory device: unwritten bytes read back as addr[7:0]
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr]     <= bus.mem_wdata;
        mem_vld[bus.mem_addr] <= 1'b1;
      end else begin
        bus.mem_rdata <= mem_vld[bus.mem_addr] ?
          mem[bus.mem_addr] : bus.mem_addr[7:0];
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // issue one command, drive the byte streams and check every cycle
  task automatic run_cmd(input logic [7:0] op,
                         input logic [15:0] ext,
                         input logic [15:0] sz,
                         input int pct,
                         input int stall,
                         input bit poke,
                         output int end_cyc,
                         output int first_vld);
    bit is_wr, is_rd, exp_err, fin, poked, vld_exp, done_exp;
    int k, cyc, s, nvld, budget;
    logic [15:0] a;
    is_wr = (op == OP_WR) && (sz != 0);
    is_rd = (op == OP_RD) && (sz != 0);
    exp_err = !(is_wr || is_rd);
    k = 0; cyc = 0; s = 1; nvld = 0;
    fin = 0; poked = 0;
    end_cyc = -1; first_vld = -1;
    budget = 60 * int'(sz) + 20;
    chk("cmd_rdy_pre", bus.cmd_rdy, 1'b1);
    bus.cmd_en = 1'b1;
    bus.cmd_op = op;
    bus.cmd_extend = ext;
    bus.wr_size = sz;
    bus.wr_vld = 1'b0;
    bus.rd_rdy = 1'b0;
    while (!fin && cyc < budget) begin
      @(negedge clk);
      cyc++;
      bus.cmd_en = 1'b0;
      a = ext + 16'(k);
      done_exp = !exp_err && (k == int'(sz));
      vld_exp = is_rd && !done_exp && (cyc >= s + 2);
      bus.wr_vld = !(is_wr && done_exp) &&
                   ($urandom_range(99) < pct);
      bus.wr_data = 8'($urandom);
      bus.rd_rdy = (!vld_exp || nvld >= stall) &&
                   ($urandom_range(99) < pct);
      if (poke && !poked && vld_exp) begin
        bus.cmd_en = 1'b1;
        bus.cmd_op = OP_WR;
        bus.cmd_extend = 16'h1234;
        bus.wr_size = 16'd1;
        poked = 1;
      end
      if (vld_exp) begin
        if (first_vld < 0) first_vld = cyc;
        nvld++;
      end
      #1;
      chk("cmd_rdy_busy", bus.cmd_rdy, 1'b0);
      chk("cmd_done", bus.cmd_done, done_exp);
      chk("cmd_err", bus.cmd_err, exp_err && cyc == 1);
      chk("wr_rdy", bus.wr_rdy, is_wr && !done_exp);
      chk("rd_vld", bus.rd_vld, vld_exp);
      if (exp_err || done_exp) begin
        chk("mem_en_idle", bus.mem_en, 1'b0);
        fin = 1;
        end_cyc = cyc;
      end else if (is_wr) begin
        chk("wr_mem_en", bus.mem_en, bus.wr_vld);
        if (bus.wr_vld) begin
          chk("wr_mem_we", bus.mem_we, 1'b1);
          chk("wr_addr", bus.mem_addr, a);
          chk("wr_wdata", bus.mem_wdata, bus.wr_data);
          ref_mem[a] = bus.wr_data;
          k++;
        end
      end else begin
        chk("rd_mem_en", bus.mem_en, cyc == s);
        if (cyc == s) begin
          chk("rd_mem_we", bus.mem_we, 1'b0);
          chk("rd_addr", bus.mem_addr, a);
        end
        if (vld_exp) begin
          chk("rd_data", bus.rd_data, ref_mem[a]);
          if (bus.rd_rdy) begin
            k++;
            s = cyc + 1;
          end
        end
      end
    end
    if (!fin) begin
      vecs++;
      errs++;
      $display("FAIL timeout op=%0h ext=%0h: got %0d of %0d bytes",
               op, ext, k, sz);
    end
    @(negedge clk);
    bus.cmd_en = 1'b0;
    bus.wr_vld = 1'b0;
    bus.rd_rdy = 1'b0;
    #1;
    chk("cmd_rdy_post", bus.cmd_rdy, 1'b1);
    chk("pulse_post", bus.cmd_done | bus.cmd_err, 1'b0);
  endtask

  initial begin
    int e, f;
    bus.cmd_en = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_extend = '0;
    bus.wr_size = '0;
    bus.wr_vld = 1'b0;
    bus.wr_data = '0;
    bus.rd_rdy = 1'b0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'(i);

    tbl[0]  = '{8'h01, 16'h0010, 16'd3,   100, 4};
    tbl[1]  = '{8'h7E, 16'h0040, 16'd4,   100, 1};
    tbl[2]  = '{8'h01, 16'h0050, 16'd0,   100, 1};
    tbl[3]  = '{8'h02, 16'h0060, 16'd0,   100, 1};
    tbl[4]  = '{8'h00, 16'h0070, 16'd2,   100, 1};
    tbl[5]  = '{8'h01, 16'hFFFE, 16'd4,   100, 5};
    tbl[6]  = '{8'h02, 16'hFFFE, 16'd4,   100, 13};
    tbl[7]  = '{8'h01, 16'h0100, 16'd1,   100, 2};
    tbl[8]  = '{8'h02, 16'h0100, 16'd1,   100, 4};
    tbl[9]  = '{8'h01, 16'h0400, 16'd300, 100, 301};
    tbl[10] = '{8'h02, 16'h0400, 16'd20,  100, 61};
    tbl[11] = '{8'h01, 16'h1000, 16'd6,   40,  -1};
    tbl[12] = '{8'h02, 16'h1000, 16'd6,   40,  -1};
    tbl[13] = '{8'hFF, 16'h2000, 16'd1,   100, 1};

    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_outs",
          {bus.cmd_rdy, bus.wr_rdy, bus.rd_vld, bus.rd_data,
           bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
           bus.cmd_done, bus.cmd_err}, 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_rdy", bus.cmd_rdy, 1'b1);

    run_cmd(OP_RD, 16'hFFFF, 16'd2, 100, 4, 1'b0, e, f);
    chk("rdw_first_vld", f, 3);
    chk("rdw_end", e, 11);

    for (int i = 0; i < 14; i++) begin
      run_cmd(tbl[i].op, tbl[i].ext, tbl[i].sz,
              tbl[i].pct, 0, 1'b0, e, f);
      if (tbl[i].exp_end >= 0) chk("tbl_end", e, tbl[i].exp_end);
    end

    chk("ab_rdy", bus.cmd_rdy, 1'b1);
    bus.cmd_en = 1'b1;
    bus.cmd_op = OP_WR;
    bus.cmd_extend = 16'h0200;
    bus.wr_size = 16'd5;
    bus.wr_vld = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      bus.cmd_en = 1'b0;
      bus.wr_data = 8'h10 + 8'(c);
      #1;
      chk("ab_wr_en", bus.mem_en, 1'b1);
      chk("ab_wr_addr", bus.mem_addr, 16'h01FF + 16'(c));
      ref_mem[16'h01FF + 16'(c)] = bus.wr_data;
    end
    @(negedge clk);
    bus.wr_vld = 1'b0;
    clr_core = 1'b1;
    #1;
    chk("ab_wr_rdy_pre", bus.wr_rdy, 1'b1);
    chk("ab_mem_en_pre", bus.mem_en, 1'b0);
    @(negedge clk);
    clr_core = 1'b0;
    #1;
    chk("ab_wr_rdy", bus.wr_rdy, 1'b0);
    chk("ab_mem_en", bus.mem_en, 1'b0);
    chk("ab_pulse", bus.cmd_done | bus.cmd_err, 1'b0);
    @(negedge clk);
    #1;
    chk("ab_rdy_post", bus.cmd_rdy, 1'b1);
    chk("ab_done_post", bus.cmd_done, 1'b0);
    run_cmd(OP_WR, 16'h0300, 16'd3, 100, 0, 1'b0, e, f);
    chk("ab_fresh_end", e, 4);
    run_cmd(OP_RD, 16'h0200, 16'd3, 100, 0, 1'b0, e, f);

    run_cmd(OP_RD, 16'h0500, 16'd3, 100, 2, 1'b1, e, f);
    chk("poke_end", e, 12);

    for (int i = 0; i < 25; i++) begin
      int r;
      logic [7:0] rop;
      r = int'($urandom_range(9));
      rop = (r < 4) ? OP_WR : ((r < 8) ? OP_RD : 8'($urandom));
      run_cmd(rop, 16'($urandom), 16'($urandom_range(8)),
              int'($urandom_range(100, 30)),
              int'($urandom_range(2)), 1'b0, e, f);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
